fetch_unit: RTL
===============

# fetch_unit

Parametrised, decoupled instruction-fetch stage replacing the single-cycle fetch datapath. It owns the PC register and issues requests to an instruction memory with variable latency. Returned instructions are buffered in a small in-order queue that feeds decode through a valid/ready handshake. Redirects (branch/jump/exception) and halts are supported without ever delivering a stale instruction.

## Interface
Parameters:
- `DATA_W`, default 16: instruction width.
- `ADDR_W`, default 16: PC/address width.
- `PC_STEP`, default 1: sequential PC increment.
- `RESET_PC`, default 0: PC loaded on reset.
- `BUF_DEPTH`, default 4: instruction queue entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_addr` out ADDR_W: request address.
- `imem_rsp_valid` in 1: response valid; responses return in request order, at least 1 cycle after acceptance.
- `imem_rsp_data` in DATA_W: returned instruction.
- `dec_valid` out 1: queue head valid.
- `dec_ready` in 1: decode consumes the head.
- `dec_instr` out DATA_W: head instruction.
- `dec_pc` out ADDR_W: head instruction address.
- `dec_next_pc` out ADDR_W: `dec_pc + PC_STEP`, mod 2^ADDR_W.
- `redirect_valid` in 1: flush and restart at `redirect_pc`.
- `redirect_pc` in ADDR_W: redirect target.
- `halt` in 1: stop issuing (HALT decoded).
- `halted` out 1: in HALTED state with nothing outstanding.

## Operation
- FSM states:
  - RUN: issue requests.
  - HALTED: no requests issued.
  - Transitions: RUN→HALTED on `halt`; HALTED→RUN on `redirect_valid` only. `halt` and `redirect_valid` in the same cycle → RUN (redirect wins).
- Request issue: `imem_req_valid` = RUN && (queue_count + outstanding < BUF_DEPTH); `imem_addr` = PC.
- Acceptance (`req_valid && req_ready`): PC += PC_STEP (wraps mod 2^ADDR_W), outstanding += 1, and the request address is pushed into an internal address FIFO (depth BUF_DEPTH).
- Response: pop the address FIFO, outstanding −= 1. If discard_count > 0, drop the response and decrement discard_count. Otherwise enqueue {instr, addr}.
- Credit rule guarantees the queue never overflows; a response arriving with the queue full is an assertion failure.
- Dequeue on `dec_valid && dec_ready`. A simultaneous enqueue and dequeue when full or empty is legal (count unchanged).
- Redirect (takes priority over everything in its cycle):
  - PC ← `redirect_pc`.
  - Queue cleared; a same-cycle dequeue is ignored.
  - discard_count ← outstanding after this cycle's acceptance and response. A request accepted in the redirect cycle carries the old PC and is discarded; a response in the redirect cycle is dropped.
  - The next request uses `redirect_pc`.
- No instruction whose address predates the most recent redirect reaches `dec_*`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - PC = RESET_PC, state RUN.
  - Queue, outstanding and discard_count = 0.
  - Outputs: `dec_valid` 0, `dec_instr`/`dec_pc` 0, `dec_next_pc` = PC_STEP, `imem_req_valid` 0 while in reset, `halted` 0.
- First request in the first cycle after release. Reset mid-operation discards everything; responses arriving for pre-reset requests are the memory's responsibility (it must also be reset).
- Latency: a response in cycle N gives `dec_valid` in N+1 (registered queue, no bypass).
- `dec_*` outputs are registered/queue-driven. `imem_req_valid` is combinational from state and counts only, never from `imem_req_ready`.
- Throughput: one instruction per cycle sustained when memory latency ≤ BUF_DEPTH−1 cycles and decode is always ready.
- `halted` asserts the cycle after HALTED is entered with outstanding == 0, or as soon as outstanding reaches 0.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state enum (RUN, HALTED);
  - the queue entry typedef {instr, pc};
  - the default widths.
- One sub-module: `fetch_fifo`, a parametrised synchronous FIFO (WIDTH, DEPTH; push, pop, flush, count, full, empty).
  - It is instantiated twice: the address FIFO and the instruction queue.
- Top-level logic covers the PC, FSM, outstanding/discard counters and `dec_next_pc` adder. Counters are $clog2(BUF_DEPTH)+1 bits.

## Test plan
- Reset with 1-cycle memory and decode always ready → `imem_addr` 0,1,2,… from the first post-reset cycle; `dec_pc` 0,1,2,… one per cycle after a 2-cycle fill, `dec_next_pc` = `dec_pc`+1.
- Decode stalled (`dec_ready`=0), BUF_DEPTH=4 → exactly 4 requests issued, then `imem_req_valid`=0. One dequeue → one new request.
- Memory latency 3 with 3 outstanding (addrs 8,9,10); redirect to 0x40 → the 3 responses are dropped, first `dec_pc` = 0x40, never 8/9/10.
- Redirect in the same cycle as a response and a decode handshake → queue empty next cycle, response dropped, next request addr = `redirect_pc`.
- PC = 0xFFFF with PC_STEP=1 → next request addr 0x0000, `dec_next_pc` 0x0000.
- `halt` with 2 outstanding → no further requests; both instructions delivered, then `halted`=1. Redirect to 0x10 → RUN, `halted`=0, request 0x10.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the decoupled instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned DEFAULT_DATA_W = 16;
   localparam int unsigned DEFAULT_ADDR_W = 16;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [DEFAULT_DATA_W-1:0] instr;
      logic [DEFAULT_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory and decode handshakes of the fetch stage.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rsp_valid;
   logic [DATA_W-1:0] imem_rsp_data;
   logic              dec_valid;
   logic              dec_ready;
   logic [DATA_W-1:0] dec_instr;
   logic [ADDR_W-1:0] dec_pc;
   logic [ADDR_W-1:0] dec_next_pc;

   modport master (
      output imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc, dec_next_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc, dec_next_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head reads as zero while empty.
module fetch_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr_q];

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; validity is carried entirely by count_q.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch: PC, credit-limited requests, in-order queue to decode,
// redirect flush with discard of in-flight responses, and halt.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
   parameter int unsigned PC_STEP   = 1,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   fetch_if.master           bus,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              halted
);

   localparam int unsigned       CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

   typedef logic [CNT_W-1:0] cnt_t;

   // Same layout as fetch_entry_t, sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
   } queue_entry_t;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, rsp_addr;
   cnt_t              outstanding_q, outstanding_d, discard_q, discard_d;
   cnt_t              q_count, af_count;
   logic              accept, rsp, enq, deq;
   logic              q_full, q_empty, af_full, af_empty;
   queue_entry_t      q_din, q_head;

   assign rsp = bus.imem_rsp_valid;
   assign bus.imem_req_valid = rst && (state_q == RUN) &&
      (({1'b0, q_count} + {1'b0, outstanding_q}) < {1'b0, cnt_t'(BUF_DEPTH)});
   assign bus.imem_addr = pc_q;
   assign accept = bus.imem_req_valid && bus.imem_req_ready;

   assign enq   = rsp && (discard_q == '0) && !redirect_valid;
   assign deq   = bus.dec_valid && bus.dec_ready && !redirect_valid;
   assign q_din = '{instr: bus.imem_rsp_data, pc: rsp_addr};

   fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(BUF_DEPTH)) u_addr_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (rsp),
      .flush (1'b0),
      .din   (pc_q),
      .dout  (rsp_addr),
      .count (af_count),
      .full  (af_full),
      .empty (af_empty)
   );

   fetch_fifo #(.WIDTH($bits(queue_entry_t)), .DEPTH(BUF_DEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (enq),
      .pop   (deq),
      .flush (redirect_valid),
      .din   (q_din),
      .dout  (q_head),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   assign bus.dec_valid   = !q_empty;
   assign bus.dec_instr   = q_head.instr;
   assign bus.dec_pc      = q_head.pc;
   assign bus.dec_next_pc = q_head.pc + STEP;
   assign halted          = (state_q == HALTED) && (outstanding_q == '0);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(rsp);
      discard_d     = discard_q;
      if (redirect_valid)  state_d = RUN;
      else if (halt)       state_d = HALTED;
      // Everything still in flight after a redirect belongs to the old path.
      if (redirect_valid)                 discard_d = outstanding_d;
      else if (rsp && discard_q != '0)    discard_d = discard_q - cnt_t'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RUN;
         pc_q          <= ADDR_W'(RESET_PC);
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         if (redirect_valid) pc_q <= redirect_pc;
         else if (accept)    pc_q <= pc_q + STEP;
      end
   end

   a_no_queue_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(enq && q_full && !deq));
   a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
      rsp |-> !af_empty);
   a_addr_fifo_room: assert property (@(posedge clk) disable iff (!rst)
      accept |-> !af_full);
   a_outstanding_tracks: assert property (@(posedge clk) disable iff (!rst)
      af_count == outstanding_q);

endmodule
